// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start-glitch rejection, framing/overrun
// reporting, FIFO write via w_en/full. Define UART_RX_PARITY_EN to add a parity bit check.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 full,
  output logic                 w_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(CPB);
  localparam int HALF = CPB / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state, nxt;
  logic                   rx_meta, rx_s, rx_d;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   sh;
  logic                   frame_q, done_q;
  logic                   tick, enter, fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // tick: a mid-bit sample this cycle; enter: a state change that restarts the counters
  always_comb begin
    nxt   = state;
    tick  = 1'b0;
    enter = 1'b0;
    fin   = 1'b0;
    case (state)
      S_IDLE: if (rx_d && !rx_s) begin
        nxt   = S_START;
        enter = 1'b1;
      end
      S_START: if (cnt == HALF_M1) begin
        tick  = 1'b1;
        enter = 1'b1;
        nxt   = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt == CPB_M1) begin
        tick = 1'b1;
        if (bit_cnt == DB_M1) begin
          enter = 1'b1;
`ifdef UART_RX_PARITY_EN
          nxt   = S_PARITY;
`else
          nxt   = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt == CPB_M1) begin
        tick  = 1'b1;
        enter = 1'b1;
        nxt   = S_STOP;
      end
`endif
      S_STOP: if (cnt == CPB_M1) begin
        tick = 1'b1;
        if (bit_cnt == SB_M1) begin
          enter = 1'b1;
          fin   = 1'b1;
          nxt   = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
      data_out <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (state == S_IDLE || enter || tick) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
      if (enter)     bit_cnt <= '0;
      else if (tick) bit_cnt <= bit_cnt + 1'b1;
      if (state == S_DATA && tick) sh <= {rx_s, sh[DATA_BITS-1:1]};
      if (state == S_START)                   frame_q <= 1'b0;
      else if (state == S_STOP && tick && !rx_s) frame_q <= 1'b1;
      done_q <= fin;
      // loaded at the last stop sample so it is valid throughout the completion cycle
      if (fin) data_out <= sh;
    end
  end

  // completion outcomes; full only matters in the cycle done_q is high
  assign busy        = (state != S_IDLE);
  assign frame_err   = done_q & frame_q;
  assign overrun_err = done_q & ~frame_q & full;
  assign w_en        = done_q & ~frame_q & ~full;

`ifdef UART_RX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              par_q <= 1'b0;
    else if (state == S_START)               par_q <= 1'b0;
    else if (state == S_PARITY && tick)      par_q <= ^sh ^ rx_s ^ 1'(PARITY_ODD);
  end
  assign parity_err = w_en & par_q;
`else
  localparam int unused_parity_odd = PARITY_ODD;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance (a) and 5-data/2-stop instance (b), both 16 clk/bit.
module tb_uart_rx_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rx_a, full_a, w_en_a, par_a, fe_a, ov_a, busy_a;
  logic [7:0] data_a;
  logic rst_b, rx_b, full_b, w_en_b, par_b, fe_b, ov_b, busy_b;
  logic [4:0] data_b;

  uart_rx_param #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_a), .rx(rx_a), .full(full_a), .w_en(w_en_a), .data_out(data_a),
    .parity_err(par_a), .frame_err(fe_a), .overrun_err(ov_a), .busy(busy_a));

  uart_rx_param #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst_n(rst_b), .rx(rx_b), .full(full_b), .w_en(w_en_b), .data_out(data_b),
    .parity_err(par_b), .frame_err(fe_b), .overrun_err(ov_b), .busy(busy_b));

`ifdef UART_RX_PARITY_EN
  localparam int NA = 11, NB = 9, LAT_A = 2 + 8 + 10*16 + 1;
`else
  localparam int NA = 10, NB = 8, LAT_A = 2 + 8 + 9*16 + 1;
`endif

  int total = 0, bad = 0;
  int pidx = 0;
  int wa_cnt = 0, wa_idx = 0, wa_prev_idx = 0, fa_cnt = 0, oa_cnt = 0, pa_cnt = 0;
  logic [7:0] wa_data = '0, wa_prev_data = '0;
  logic wa_par = 1'b0;
  int wb_cnt = 0, fb_cnt = 0;
  logic [4:0] wb_data = '0;

  always @(posedge clk) begin
    #1;
    pidx++;
    if (w_en_a) begin
      wa_prev_idx = wa_idx; wa_prev_data = wa_data;
      wa_cnt++; wa_idx = pidx; wa_data = data_a; wa_par = par_a;
    end
    if (fe_a) fa_cnt++;
    if (ov_a) oa_cnt++;
    if (par_a) pa_cnt++;
    if (w_en_b) begin wb_cnt++; wb_data = data_b; end
    if (fe_b) fb_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fa(input logic [7:0] d, input logic p, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {5'b0, stop, p, d, 1'b0};
`else
    return {6'b0, stop, d, 1'b0};
`endif
  endfunction

  function automatic logic [15:0] fb(input logic [4:0] d, input logic s1, input logic s2);
`ifdef UART_RX_PARITY_EN
    return {7'b0, s2, s1, ^d, d, 1'b0};
`else
    return {8'b0, s2, s1, d, 1'b0};
`endif
  endfunction

  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = bits[i]; else rx_b = bits[i];
      repeat (16) @(negedge clk);
    end
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
  endtask

  int s, base_w, base_f;

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; full_a = 1'b0; full_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_w_en", w_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_errs", {fe_a, ov_a, par_a}, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // basic frame and its exact completion latency
    s = pidx;
    send(0, fa(8'hA5, 1'b0, 1'b1), NA);
    repeat (20) @(negedge clk);
    chk("basic_cnt", wa_cnt, 1);
    chk("basic_data", wa_data, 8'hA5);
    chk("basic_lat", wa_idx - s, LAT_A);
    chk("basic_noerr", fa_cnt + oa_cnt + pa_cnt, 0);

    // 4-cycle glitch
    rx_a = 1'b0; repeat (4) @(negedge clk);
    rx_a = 1'b1; repeat (3) @(negedge clk);
    chk("glitch_busy_hi", busy_a, 1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_lo", busy_a, 0);
    chk("glitch_no_w", wa_cnt, 1);

    // back-to-back
    send(0, fa(8'h3C, 1'b0, 1'b1), NA);
    send(0, fa(8'hC3, 1'b0, 1'b1), NA);
    repeat (20) @(negedge clk);
    chk("b2b_cnt", wa_cnt, 3);
    chk("b2b_d1", wa_prev_data, 8'h3C);
    chk("b2b_d2", wa_data, 8'hC3);
    chk("b2b_gap", wa_idx - wa_prev_idx, 160);

    // bad stop bit
    send(0, fa(8'h55, 1'b0, 1'b0), NA);
    repeat (20) @(negedge clk);
    chk("fe_cnt", fa_cnt, 1);
    chk("fe_no_w", wa_cnt, 3);
    chk("fe_data", data_a, 8'h55);

    // break: one frame error, then a held-low line is ignored
    rx_a = 1'b0;
    repeat (320) @(negedge clk);
    chk("brk_fe", fa_cnt, 2);
    chk("brk_idle", busy_a, 0);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("brk_quiet", wa_cnt + fa_cnt, 5);
    send(0, fa(8'h81, 1'b0, 1'b1), NA);
    repeat (20) @(negedge clk);
    chk("brk_rearm", wa_data, 8'h81);

    // overrun
    full_a = 1'b1;
    send(0, fa(8'h7E, 1'b0, 1'b1), NA);
    repeat (20) @(negedge clk);
    full_a = 1'b0;
    chk("ovr_cnt", oa_cnt, 1);
    chk("ovr_no_w", wa_cnt, 4);
    chk("ovr_data", data_a, 8'h7E);

`ifdef UART_RX_PARITY_EN
    send(0, fa(8'h03, 1'b0, 1'b1), NA);
    repeat (20) @(negedge clk);
    chk("par_ok_w", wa_cnt, 5);
    chk("par_ok_flag", wa_par, 0);
    send(0, fa(8'h03, 1'b1, 1'b1), NA);
    repeat (20) @(negedge clk);
    chk("par_bad_w", wa_cnt, 6);
    chk("par_bad_flag", wa_par, 1);
`endif

    // narrow instance: second stop bit low
    send(1, fb(5'h0A, 1'b1, 1'b0), NB);
    repeat (20) @(negedge clk);
    chk("b_fe", fb_cnt, 1);
    chk("b_fe_no_w", wb_cnt, 0);
    chk("b_fe_data", data_b, 5'h0A);

    // reset during data bit 3 of an all-ones character
    rx_b = 1'b0; repeat (16) @(negedge clk);
    rx_b = 1'b1; repeat (40) @(negedge clk);
    chk("b_mid_busy", busy_b, 1);
    rst_b = 1'b0;
    #1;
    chk("b_rst_outs", {busy_b, w_en_b, fe_b, ov_b, par_b, data_b}, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (160) @(negedge clk);
    chk("b_rst_quiet", wb_cnt + fb_cnt, 1);
    send(1, fb(5'h15, 1'b1, 1'b1), NB);
    repeat (20) @(negedge clk);
    chk("b_after_cnt", wb_cnt, 1);
    chk("b_after_data", wb_data, 5'h15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
